// File: rtl/ddr2_cmd_sequencer.sv
// DDR2 command sequencer: validates scheduler commands against open-row state, drives one-cycle
// command pins with tRCD/tRP/tRFC/tMRD/tCCD spacing and ODT around writes. Optional: DDR2_AUTO_REFRESH_EN.
module ddr2_cmd_sequencer #(
    parameter int ROW_ADDRESS  = 13,
    parameter int BANK_ADDRESS = 2,
    parameter int CS_WIDTH     = 1,
    parameter int CKE_WIDTH    = 1,
    parameter int ODT_WIDTH    = 1,
    parameter int T_RCD        = 3,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 26,
    parameter int T_MRD        = 2,
    parameter int T_CCD        = 2,
    parameter int ODT_HOLD     = 4,
    parameter int T_REFI       = 1560
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    cke_req,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_type,
    input  logic [ROW_ADDRESS-1:0]  cmd_addr,
    input  logic [BANK_ADDRESS-1:0] cmd_ba,
    input  logic [CS_WIDTH-1:0]     cmd_cs,
    output logic                    cmd_err,
    output logic                    ref_active,
    output logic [ROW_ADDRESS-1:0]  ctrl_ddr2_address,
    output logic [BANK_ADDRESS-1:0] ctrl_ddr2_ba,
    output logic                    ctrl_ddr2_ras_l,
    output logic                    ctrl_ddr2_cas_l,
    output logic                    ctrl_ddr2_we_l,
    output logic [CS_WIDTH-1:0]     ctrl_ddr2_cs_l,
    output logic [CKE_WIDTH-1:0]    ctrl_ddr2_cke,
    output logic [ODT_WIDTH-1:0]    ctrl_ddr2_odt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int BANKS    = 1 << BANK_ADDRESS;
    localparam int WAIT_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RFC, T_MRD)), T_CCD);
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int ODT_W    = $clog2(ODT_HOLD + 1);
    localparam int A10      = 10;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0, CMD_ACT = 3'd1, CMD_RD  = 3'd2, CMD_WR  = 3'd3,
        CMD_PRE  = 3'd4, CMD_PREA = 3'd5, CMD_REF = 3'd6, CMD_LMR = 3'd7
    } cmd_t;

    logic [WAIT_W-1:0]       wait_cnt, nxt_wait;
    logic [BANKS-1:0]        bank_open, nxt_bank;
    logic [ODT_W-1:0]        odt_cnt;
    logic                    odt_on;
    logic [2:0]              nxt_rcw;
    logic [ROW_ADDRESS-1:0]  nxt_addr;
    logic [BANK_ADDRESS-1:0] nxt_ba;
    logic [CS_WIDTH-1:0]     nxt_cs_l;
    logic                    nxt_err, wr_issue, accept, cke_on, ref_pending, ref_busy;
    cmd_t                    cmd;

`ifdef DDR2_AUTO_REFRESH_EN
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} ref_state_t;
    localparam int REFI_W = $clog2(T_REFI + 1);
    ref_state_t        ref_state, nxt_ref_state;
    logic [REFI_W-1:0] refi_cnt;
    logic              ref_reload;

    assign ref_pending = (refi_cnt == '0);
    assign ref_busy    = (ref_state != R_IDLE);
`else
    assign ref_pending = 1'b0;
    assign ref_busy    = 1'b0;
`endif

    assign cmd         = cmd_t'(cmd_type);
    assign cke_on      = ctrl_ddr2_cke[0];
    assign cmd_ready   = !rst0 && cke_on && (wait_cnt == '0) && !ref_pending && !ref_busy;
    assign accept      = cmd_valid && cmd_ready;
    assign ref_active  = ref_busy;

    always_comb begin
        nxt_rcw  = 3'b111;
        nxt_addr = '0;
        nxt_ba   = '0;
        nxt_cs_l = '1;
        nxt_err  = 1'b0;
        nxt_bank = bank_open;
        nxt_wait = (wait_cnt != '0) ? wait_cnt - WAIT_W'(1) : '0;
        wr_issue = 1'b0;
`ifdef DDR2_AUTO_REFRESH_EN
        nxt_ref_state = ref_state;
        ref_reload    = 1'b0;
`endif
        if (accept) begin
            case (cmd)
                CMD_ACT: if (bank_open[cmd_ba]) nxt_err = 1'b1;
                         else begin
                             nxt_rcw = 3'b011; nxt_addr = cmd_addr; nxt_ba = cmd_ba;
                             nxt_cs_l = ~cmd_cs; nxt_wait = WAIT_W'(T_RCD - 1);
                             nxt_bank[cmd_ba] = 1'b1;
                         end
                CMD_RD, CMD_WR: if (!bank_open[cmd_ba]) nxt_err = 1'b1;
                         else begin
                             nxt_rcw = (cmd == CMD_RD) ? 3'b101 : 3'b100;
                             nxt_addr = cmd_addr; nxt_addr[A10] = 1'b0; nxt_ba = cmd_ba;
                             nxt_cs_l = ~cmd_cs; nxt_wait = WAIT_W'(T_CCD - 1);
                             wr_issue = (cmd == CMD_WR);
                         end
                CMD_PRE: if (!bank_open[cmd_ba]) nxt_err = 1'b1;
                         else begin
                             nxt_rcw = 3'b010; nxt_ba = cmd_ba; nxt_cs_l = ~cmd_cs;
                             nxt_wait = WAIT_W'(T_RP - 1); nxt_bank[cmd_ba] = 1'b0;
                         end
                CMD_PREA: begin
                             nxt_rcw = 3'b010; nxt_addr[A10] = 1'b1; nxt_ba = cmd_ba;
                             nxt_cs_l = ~cmd_cs; nxt_wait = WAIT_W'(T_RP - 1); nxt_bank = '0;
                         end
                CMD_REF: if (|bank_open) nxt_err = 1'b1;
                         else begin
                             nxt_rcw = 3'b001; nxt_cs_l = ~cmd_cs; nxt_wait = WAIT_W'(T_RFC - 1);
                         end
                CMD_LMR: if (|bank_open) nxt_err = 1'b1;
                         else begin
                             nxt_rcw = 3'b000; nxt_addr = cmd_addr; nxt_ba = cmd_ba;
                             nxt_cs_l = ~cmd_cs; nxt_wait = WAIT_W'(T_MRD - 1);
                         end
                default: ;
            endcase
        end
`ifdef DDR2_AUTO_REFRESH_EN
        // Refresh never overlaps an accepted command: cmd_ready is low whenever pending/busy.
        case (ref_state)
            R_IDLE:  if (ref_pending && wait_cnt == '0 && cke_on) nxt_ref_state = R_ISSUE;
            R_ISSUE: if (wait_cnt == '0) begin
                         nxt_cs_l = '0;
                         if (|bank_open) begin
                             nxt_rcw = 3'b010; nxt_addr[A10] = 1'b1;
                             nxt_wait = WAIT_W'(T_RP - 1); nxt_bank = '0;
                         end else begin
                             nxt_rcw = 3'b001; nxt_wait = WAIT_W'(T_RFC - 1);
                             ref_reload = 1'b1; nxt_ref_state = R_WAIT;
                         end
                     end
            R_WAIT:  if (wait_cnt == '0) nxt_ref_state = R_IDLE;
            default: nxt_ref_state = R_IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            ctrl_ddr2_cke     <= '0;
            ctrl_ddr2_address <= '0;
            ctrl_ddr2_ba      <= '0;
            ctrl_ddr2_cs_l    <= '1;
            {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l} <= 3'b111;
            cmd_err           <= 1'b0;
            wait_cnt          <= '0;
            bank_open         <= '0;
            odt_on            <= 1'b0;
            odt_cnt           <= '0;
        end else begin
            ctrl_ddr2_cke     <= {CKE_WIDTH{cke_req}};
            ctrl_ddr2_address <= nxt_addr;
            ctrl_ddr2_ba      <= nxt_ba;
            ctrl_ddr2_cs_l    <= nxt_cs_l;
            {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l} <= nxt_rcw;
            cmd_err           <= nxt_err;
            wait_cnt          <= nxt_wait;
            bank_open         <= nxt_bank;
            // A write during the hold window restarts the full ODT_HOLD count.
            if (wr_issue) begin
                odt_on  <= 1'b1;
                odt_cnt <= ODT_W'(ODT_HOLD - 1);
            end else if (odt_cnt != '0) begin
                odt_cnt <= odt_cnt - ODT_W'(1);
            end else begin
                odt_on  <= 1'b0;
            end
        end
    end

    assign ctrl_ddr2_odt = {ODT_WIDTH{odt_on}};

`ifdef DDR2_AUTO_REFRESH_EN
    always_ff @(posedge clk0) begin
        if (rst0) begin
            ref_state <= R_IDLE;
            refi_cnt  <= REFI_W'(T_REFI - 1);
        end else begin
            ref_state <= nxt_ref_state;
            if (ref_reload)          refi_cnt <= REFI_W'(T_REFI - 1);
            else if (refi_cnt != '0) refi_cnt <= refi_cnt - REFI_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// Directed self-checking bench for ddr2_cmd_sequencer (default build, default parameters).
module tb_ddr2_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst0, cke_req, cmd_valid, cmd_ready, cmd_err, ref_active;
    logic [2:0]  cmd_type;
    logic [12:0] cmd_addr, ctrl_ddr2_address;
    logic [1:0]  cmd_ba, ctrl_ddr2_ba;
    logic [0:0]  cmd_cs, ctrl_ddr2_cs_l, ctrl_ddr2_cke, ctrl_ddr2_odt;
    logic        ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l;

    int n_tests = 0;
    int n_fail  = 0;
    int odt_hi  = 0;
    int lat;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3,
                           PRE = 3'd4, PREA = 3'd5, REF = 3'd6, LMR = 3'd7;

    ddr2_cmd_sequencer dut (
        .clk0(clk), .rst0(rst0), .cke_req(cke_req),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_ba(cmd_ba), .cmd_cs(cmd_cs),
        .cmd_err(cmd_err), .ref_active(ref_active),
        .ctrl_ddr2_address(ctrl_ddr2_address), .ctrl_ddr2_ba(ctrl_ddr2_ba),
        .ctrl_ddr2_ras_l(ctrl_ddr2_ras_l), .ctrl_ddr2_cas_l(ctrl_ddr2_cas_l),
        .ctrl_ddr2_we_l(ctrl_ddr2_we_l), .ctrl_ddr2_cs_l(ctrl_ddr2_cs_l),
        .ctrl_ddr2_cke(ctrl_ddr2_cke), .ctrl_ddr2_odt(ctrl_ddr2_odt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ctrl_ddr2_odt != '0) odt_hi++;
    endtask

    task automatic pins(input string tag, input logic [2:0] rcw, input logic [12:0] a,
                        input logic [1:0] b, input logic cs_l);
        check({tag, " rcw"}, {ctrl_ddr2_ras_l, ctrl_ddr2_cas_l, ctrl_ddr2_we_l}, rcw);
        check({tag, " addr"}, ctrl_ddr2_address, a);
        check({tag, " ba"}, ctrl_ddr2_ba, b);
        check({tag, " cs_l"}, ctrl_ddr2_cs_l, cs_l);
    endtask

    // Holds the request until accepted; returns cycles from call to the pin cycle.
    task automatic send(input string tag, input logic [2:0] t, input logic [12:0] a,
                        input logic [1:0] b, output int l);
        logic acc;
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_ba = b;
        l = 0;
        do begin
            acc = cmd_ready;
            tick();
            l++;
        end while (!acc && l < 100);
        cmd_valid = 1'b0; cmd_type = NOP; cmd_addr = '0; cmd_ba = '0;
        check({tag, " accepted"}, acc, 1);
    endtask

    initial begin
        rst0 = 1'b1; cke_req = 1'b0; cmd_valid = 1'b0; cmd_type = NOP;
        cmd_addr = '0; cmd_ba = '0; cmd_cs = 1'b1;
        repeat (5) tick();
        pins("reset", 3'b111, 13'h0, 2'd0, 1'b1);
        check("reset cke", ctrl_ddr2_cke, 0);
        check("reset odt", ctrl_ddr2_odt, 0);
        check("reset ready", cmd_ready, 0);
        check("reset err", cmd_err, 0);
        check("reset ref_active", ref_active, 0);

        rst0 = 1'b0; cke_req = 1'b1;
        #1 check("ready before cke", cmd_ready, 0);
        tick();
        check("cke high", ctrl_ddr2_cke, 1);
        check("ready after cke", cmd_ready, 1);

        send("act b1", ACT, 13'h0ABC, 2'd1, lat);
        check("act b1 lat", lat, 1);
        pins("act b1", 3'b011, 13'h0ABC, 2'd1, 1'b0);
        check("act ready low", cmd_ready, 0);

        send("rd b1", RD, 13'h0410, 2'd1, lat);
        check("rd after act lat", lat, 3);
        pins("rd b1", 3'b101, 13'h0010, 2'd1, 1'b0);
        check("rd err", cmd_err, 0);

        odt_hi = 0;
        send("wr b1", WR, 13'h0020, 2'd1, lat);
        check("wr after rd lat", lat, 2);
        pins("wr b1", 3'b100, 13'h0020, 2'd1, 1'b0);
        repeat (6) tick();
        check("odt single wr cycles", odt_hi, 4);

        odt_hi = 0;
        send("wr1", WR, 13'h0030, 2'd1, lat);
        check("wr1 lat", lat, 1);
        send("wr2", WR, 13'h0040, 2'd1, lat);
        check("wr2 lat", lat, 2);
        repeat (8) tick();
        check("odt restart cycles", odt_hi, 6);

        send("rd closed", RD, 13'h0, 2'd2, lat);
        check("rd closed lat", lat, 1);
        check("rd closed err", cmd_err, 1);
        pins("rd closed", 3'b111, 13'h0, 2'd0, 1'b1);
        check("rd closed ready", cmd_ready, 1);
        tick();
        check("err one cycle", cmd_err, 0);

        send("prea", PREA, 13'h0, 2'd0, lat);
        check("prea lat", lat, 1);
        pins("prea", 3'b010, 13'h0400, 2'd0, 1'b0);
        send("ref", REF, 13'h0, 2'd0, lat);
        check("ref after prea lat", lat, 3);
        pins("ref", 3'b001, 13'h0, 2'd0, 1'b0);
        check("ref err", cmd_err, 0);
        send("act after ref", ACT, 13'h1234, 2'd0, lat);
        check("act after ref lat", lat, 26);
        pins("act b0", 3'b011, 13'h1234, 2'd0, 1'b0);

        send("lmr open", LMR, 13'h0123, 2'd0, lat);
        check("lmr open lat", lat, 3);
        check("lmr open err", cmd_err, 1);
        pins("lmr open", 3'b111, 13'h0, 2'd0, 1'b1);
        send("pre b0", PRE, 13'h1FFF, 2'd0, lat);
        check("pre after reject lat", lat, 1);
        pins("pre b0", 3'b010, 13'h0, 2'd0, 1'b0);
        send("lmr", LMR, 13'h0123, 2'd0, lat);
        check("lmr after pre lat", lat, 3);
        pins("lmr", 3'b000, 13'h0123, 2'd0, 1'b0);
        send("act b3", ACT, 13'h0055, 2'd3, lat);
        check("act after lmr lat", lat, 2);
        pins("act b3", 3'b011, 13'h0055, 2'd3, 1'b0);
        send("act b3 again", ACT, 13'h0066, 2'd3, lat);
        check("act open lat", lat, 3);
        check("act open err", cmd_err, 1);
        send("pre closed", PRE, 13'h0, 2'd1, lat);
        check("pre closed err", cmd_err, 1);

        send("act b2", ACT, 13'h0077, 2'd2, lat);
        check("act b2 lat", lat, 1);
        rst0 = 1'b1;
        tick();
        pins("mid reset", 3'b111, 13'h0, 2'd0, 1'b1);
        check("mid reset ready", cmd_ready, 0);
        check("mid reset cke", ctrl_ddr2_cke, 0);
        rst0 = 1'b0;
        tick();
        check("post reset ready", cmd_ready, 1);
        send("act b2 post reset", ACT, 13'h0088, 2'd2, lat);
        check("act b2 post reset lat", lat, 1);
        check("act b2 post reset err", cmd_err, 0);
        pins("act b2 post reset", 3'b011, 13'h0088, 2'd2, 1'b0);

        repeat (4) tick();
        check("ready before cke drop", cmd_ready, 1);
        cke_req = 1'b0;
        tick();
        check("cke low", ctrl_ddr2_cke, 0);
        check("ready cke low", cmd_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
